// File: rtl/morse_sequencer.sv
// morse_sequencer
// Plays one Morse letter on an LED by driving an external 4-bit dot/dash shift register.
// On a valid start request the register is loaded. Each symbol is timed from the register
// LSB: a dot lasts 1 unit and a dash lasts 3 units, and every symbol is followed by a 1-unit
// gap. The register is shifted between symbols.
//
// Ports:
//   CLOCK_50  in   system clock, all state on the rising edge
//   resetn    in   asynchronous active-low reset
//   start     in   play request, sampled only in IDLE
//   length    in   symbol count of the letter (1..4), sampled with start
//   sym_bit   in   current symbol from the shift register LSB (0 = dot, 1 = dash)
//   load      out  one-cycle load pulse to the shift register
//   enable    out  one-cycle shift-enable pulse to the shift register
//   led       out  Morse output, 1 = light on
//   busy      out  high from LOAD through DONE
//   done      out  one-cycle pulse when the letter has finished
module morse_sequencer #(
  parameter int unsigned DOT_TICKS = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] length,
  input  logic       sym_bit,
  output logic       load,
  output logic       enable,
  output logic       led,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TimerW = $clog2(3 * DOT_TICKS);

  localparam logic [TimerW-1:0] DotLast  = TimerW'(DOT_TICKS - 1);
  localparam logic [TimerW-1:0] DashLast = TimerW'(3 * DOT_TICKS - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MARK = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        remaining_q, remaining_d;
  // Registered "this is the final MARK cycle" flag. It keeps sym_bit out of the output
  // decode. Because DOT_TICKS >= 2, the first MARK cycle is never the last one, so the
  // flag can always be computed one cycle ahead.
  logic              last_q, last_d;
  logic [TimerW-1:0] timer_inc;

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    last_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (length != 3'd0) && (length <= 3'd4)) begin
          state_d     = LOAD;
          remaining_d = length;
          timer_d     = '0;
        end
      end
      LOAD: begin
        state_d = MARK;
        timer_d = '0;
      end
      MARK: begin
        if (last_q) begin
          state_d = GAP;
          timer_d = '0;
          if (remaining_q != 3'd0) remaining_d = remaining_q - 3'd1;
        end else begin
          timer_d = timer_inc;
          last_d  = (timer_inc == (sym_bit ? DashLast : DotLast));
        end
      end
      GAP: begin
        if (timer_q == DotLast) begin
          timer_d = '0;
          state_d = (remaining_q != 3'd0) ? MARK : DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= 3'd0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    load   = (state_q == LOAD);
    led    = (state_q == MARK);
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    // Shift only when another symbol follows, so the next symbol is ready during GAP.
    enable = (state_q == MARK) && last_q && (remaining_q > 3'd1);
  end

endmodule

// File: tb/tb_morse_sequencer.sv
module tb_morse_sequencer;

  localparam int unsigned D = 4;

  localparam int EvLoad   = 0;
  localparam int EvLedOn  = 1;
  localparam int EvLedOff = 2;
  localparam int EvEnable = 3;
  localparam int EvDone   = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [2:0] length   = 3'd0;
  logic       sym_bit;
  logic       load, enable, led, busy, done;

  logic [3:0] letter = 4'd0;
  logic [3:0] sreg   = 4'd0;
  logic       led_prev = 1'b0;

  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  morse_sequencer #(.DOT_TICKS(D)) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .start   (start),
    .length  (length),
    .sym_bit (sym_bit),
    .load    (load),
    .enable  (enable),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Cycle counter and the external dot/dash shift register model.
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (load) sreg <= letter;
    else if (enable) sreg <= sreg >> 1;
  end
  assign sym_bit = sreg[0];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic see(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Expected event timeline for one letter whose start is presented in cycle t0.
  task automatic push_letter(input int t0, input logic [3:0] l, input int n);
    int c;
    int m;
    exp_q.push_back('{EvLoad, t0 + 1});
    c = t0 + 2;
    for (int i = 0; i < n; i++) begin
      m = l[i] ? 3 * D : D;
      exp_q.push_back('{EvLedOn, c});
      if (i < n - 1) exp_q.push_back('{EvEnable, c + m - 1});
      exp_q.push_back('{EvLedOff, c + m});
      c = c + m + D;
    end
    exp_q.push_back('{EvDone, c});
  endtask

  // Monitor: compares every output event against the scoreboard queue.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (!resetn) begin
        led_prev = led;
      end else begin
        if (load) begin
          see(EvLoad);
          check("busy_at_load", busy, 1);
        end
        if (led && !led_prev) see(EvLedOn);
        if (!led && led_prev) see(EvLedOff);
        if (enable) see(EvEnable);
        if (done) begin
          see(EvDone);
          check("busy_at_done", busy, 1);
        end
        check("load_enable_exclusive", int'(load && enable), 0);
        led_prev = led;
      end
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_complete", exp_q.size(), 0);
    exp_q.delete();
    #2;
    check("busy_after_done", busy, 0);
  endtask

  task automatic play(input logic [3:0] l, input int n);
    tick();
    letter = l;
    length = 3'(n);
    start  = 1'b1;
    push_letter(cyc, l, n);
    tick();
    start = 1'b0;
    drain(200);
  endtask

  initial begin
    int t0;

    // Reset state.
    #12;
    check("rst_load", load, 0);
    check("rst_enable", enable, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Letter A: dot, dash.
    play(4'b0010, 2);
    // Four dots.
    play(4'b0000, 4);
    // Single dash.
    play(4'b0001, 1);
    // Mixed: dash, dot, dash.
    play(4'b0101, 3);

    // Invalid lengths are ignored.
    tick();
    letter = 4'b0010;
    length = 3'd0;
    start  = 1'b1;
    repeat (25) begin
      tick();
      check("busy_len0", busy, 0);
    end
    length = 3'd5;
    repeat (25) begin
      tick();
      check("busy_len5", busy, 0);
    end
    start = 1'b0;

    // start held high: one load per letter, the next letter begins after busy falls.
    tick();
    letter = 4'b0010;
    length = 3'd2;
    start  = 1'b1;
    t0 = cyc;
    push_letter(t0, 4'b0010, 2);
    push_letter(t0 + 27, 4'b0010, 2);
    while (cyc < t0 + 28) tick();
    start = 1'b0;
    drain(200);

    // Asynchronous reset during the second MARK of letter A.
    tick();
    letter = 4'b0010;
    length = 3'd2;
    start  = 1'b1;
    t0 = cyc;
    push_letter(t0, 4'b0010, 2);
    tick();
    start = 1'b0;
    while (cyc < t0 + 12) tick();
    #2;
    check("led_before_reset", led, 1);
    check("busy_before_reset", busy, 1);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_led", led, 0);
    check("midrst_busy", busy, 0);
    check("midrst_load", load, 0);
    check("midrst_enable", enable, 0);
    tick();
    tick();
    check("midrst_hold_busy", busy, 0);
    resetn = 1'b1;
    tick();
    play(4'b0010, 2);

    repeat (3) tick();
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Controller that plays one Morse letter on an LED by sequencing the 4-bit dot/dash shift register. On a start request it loads the register, times each symbol (dot = 1 unit, dash = 3 units, 1-unit gap after every symbol) from the register's current LSB, and shifts the register between symbols. It sits between the letter-select logic and the shift register / LED output.

## Interface
- DOT_TICKS, 25_000_000, clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2
- CLOCK_50  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request to play a letter; sampled only in IDLE
- length  in  3  symbol count of the letter, valid 1..4; sampled with start
- sym_bit  in  1  current symbol from the shift register LSB: 0 = dot, 1 = dash
- load  out  1  one-cycle pulse to the shift register's load input
- enable  out  1  one-cycle pulse to the shift register's shift enable
- led  out  1  Morse output, 1 = tone/light on
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse when the letter has finished

## Operation
- States: IDLE, LOAD, MARK, GAP, DONE; 2-bit-or-wider encoded state register.
- IDLE: all outputs 0. start=1 and length in 1..4 → LOAD, latch remaining=length. start with length 0 or 5..7 is ignored (stay IDLE, no pulses).
- LOAD: load=1, busy=1, exactly one cycle → MARK, timer cleared.
- MARK: led=1. target = sym_bit ? 3*DOT_TICKS : DOT_TICKS; sym_bit is stable throughout MARK. Timer counts 0..target-1; on timer==target-1: remaining decrements, → GAP, timer cleared; in that same cycle enable=1 iff remaining > 1 before decrement (shift presents the next symbol during GAP).
- GAP: led=0, runs DOT_TICKS cycles. On last cycle: remaining ≠ 0 → MARK, else → DONE.
- DONE: done=1, busy=1, one cycle → IDLE.
- start during LOAD/MARK/GAP/DONE is ignored; no queuing.
- Timer width = $clog2(3*DOT_TICKS); remaining is 3 bits, never underflows.
- load and enable are never high in the same cycle; enable never asserts on the final symbol.

## Timing
- Reset (asynchronous, immediate, including mid-letter): state=IDLE, timer=0, remaining=0; load, enable, led, busy, done all 0. Shift register contents are not cleared by this block.
- Outputs are decoded from registered state/timer only; no combinational path from start/length/sym_bit to any output except via state.
- start sampled at edge N in IDLE → load high cycle N+1 → led rises cycle N+2.
- Dot mark = DOT_TICKS cycles led=1; dash mark = 3*DOT_TICKS; every mark followed by DOT_TICKS cycles led=0.
- Letter latency, start cycle to done cycle inclusive: 1 + 1 + Σmarks + length*DOT_TICKS + 1 − 1 = 2 + Σmarks + length*DOT_TICKS cycles after start; busy falls the cycle after done.
- Back-to-back: start may be asserted the cycle busy is low again (first IDLE cycle after DONE).

## Test plan
All with DOT_TICKS=4, bench drives sym_bit from a shift register model fed by load/enable/letter.
- Letter A (letter=4'b0010, length=2), start at cycle 0 → load cycle 1; led=1 cycles 2–5; enable cycle 5 only; led=0 6–9; led=1 10–21; led=0 22–25; done cycle 26; busy 1–26.
- Letter H-style (4'b0000, length=4) → four 4-cycle marks, enable exactly 3 times, done at cycle 2+16+16=34.
- length=0 and length=5 with start=1 → no load, busy stays 0 for 50 cycles.
- start re-asserted every cycle while busy → exactly one load pulse per letter; new letter starts only after busy falls.
- resetn pulled low during second MARK of letter A → led, busy, enable, load drop same cycle (asynchronous); after release, start plays a full fresh letter with correct timing.
- Single-dash letter (4'b0001, length=1) → led high 12 cycles, no enable, 4-cycle gap, done at cycle 18.
